// File: rtl/perf_cache_csr_reader_if.sv
// Live cache performance counters, driven by the cache (master) and sampled by the reader (slave).
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 48
`endif

interface perf_cache_csr_reader_if #(
  parameter int CTR_BITS = `PERF_CTR_BITS
);
  logic [CTR_BITS-1:0] reads;
  logic [CTR_BITS-1:0] writes;
  logic [CTR_BITS-1:0] read_misses;
  logic [CTR_BITS-1:0] write_misses;
  logic [CTR_BITS-1:0] bank_stalls;
  logic [CTR_BITS-1:0] mshr_stalls;
  logic [CTR_BITS-1:0] pipe_stalls;
  logic [CTR_BITS-1:0] crsp_stalls;
  logic [CTR_BITS-1:0] prefetch_requests;
  logic [CTR_BITS-1:0] prefetched_blocks;
  logic [CTR_BITS-1:0] unused_prefetched_blocks;

  modport master (
    output reads, writes, read_misses, write_misses, bank_stalls, mshr_stalls,
           pipe_stalls, crsp_stalls, prefetch_requests, prefetched_blocks,
           unused_prefetched_blocks
  );
  modport slave (
    input reads, writes, read_misses, write_misses, bank_stalls, mshr_stalls,
          pipe_stalls, crsp_stalls, prefetch_requests, prefetched_blocks,
          unused_prefetched_blocks
  );
endinterface

// File: rtl/perf_cache_csr_reader.sv
// Snapshots 11 cache perf counters into a shadow bank and serves 32-bit word reads of it.
// Optional PERF_CACHE_DELTA_EN: snapshots store live minus a clearable baseline.
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 48
`endif

module perf_cache_csr_reader #(
  parameter int CTR_BITS   = `PERF_CTR_BITS,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  perf_cache_csr_reader_if.slave    perf_cache_if_i,
  input  logic                      snap_valid_i,
`ifdef PERF_CACHE_DELTA_EN
  input  logic                      clear_valid_i,
`endif
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [3:0]                req_idx_i,
  input  logic                      req_hi_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [DATA_WIDTH-1:0]     rsp_data_o,
  output logic                      rsp_err_o
);
  localparam int NUM_CTRS = 11;
  localparam logic [3:0] MAX_IDX = 4'(NUM_CTRS - 1);

  typedef enum logic {IDLE, RSP} state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;

  logic [CTR_BITS-1:0]    live     [NUM_CTRS];
  logic [CTR_BITS-1:0]    shadow_q [NUM_CTRS];
  logic [CTR_BITS-1:0]    shadow_d [NUM_CTRS];
  logic [DATA_WIDTH-1:0]  word_lo  [16];
  logic [DATA_WIDTH-1:0]  word_hi  [16];

  assign live[0]  = perf_cache_if_i.reads;
  assign live[1]  = perf_cache_if_i.writes;
  assign live[2]  = perf_cache_if_i.read_misses;
  assign live[3]  = perf_cache_if_i.write_misses;
  assign live[4]  = perf_cache_if_i.bank_stalls;
  assign live[5]  = perf_cache_if_i.mshr_stalls;
  assign live[6]  = perf_cache_if_i.pipe_stalls;
  assign live[7]  = perf_cache_if_i.crsp_stalls;
  assign live[8]  = perf_cache_if_i.prefetch_requests;
  assign live[9]  = perf_cache_if_i.prefetched_blocks;
  assign live[10] = perf_cache_if_i.unused_prefetched_blocks;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CTRS; gi++) begin : g_ctr
`ifdef PERF_CACHE_DELTA_EN
      logic [CTR_BITS-1:0] baseline_q;

      always_ff @(posedge clk_i) begin
        if (!reset_i)          baseline_q <= '0;
        else if (clear_valid_i) baseline_q <= live[gi];
      end

      // Width-limited subtraction makes a wrapped counter still yield the true delta.
      assign shadow_d[gi] = live[gi] - baseline_q;
`else
      assign shadow_d[gi] = live[gi];
`endif

      always_ff @(posedge clk_i) begin
        if (!reset_i)         shadow_q[gi] <= '0;
        else if (snap_valid_i) shadow_q[gi] <= shadow_d[gi];
      end
    end

    // Pad the read mux to 16 entries so indices 11..15 read as zero.
    for (gi = 0; gi < 16; gi++) begin : g_word
      if (gi < NUM_CTRS) begin : g_real
        assign word_lo[gi] = shadow_q[gi][31:0];
        assign word_hi[gi] = 32'(shadow_q[gi] >> 32);
      end else begin : g_pad
        assign word_lo[gi] = '0;
        assign word_hi[gi] = '0;
      end
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          rsp_data_d = req_hi_i ? word_hi[req_idx_i] : word_lo[req_idx_i];
          rsp_err_d  = (req_idx_i > MAX_IDX);
          state_d    = RSP;
        end
      end
      RSP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_data_o = rsp_data_q;
  assign rsp_err_o  = rsp_err_q;
endmodule

// File: tb/tb_perf_cache_csr_reader.sv
// Directed self-checking bench for perf_cache_csr_reader; inputs driven and outputs sampled at negedge.
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 48
`endif

module tb_perf_cache_csr_reader;
  localparam int CTR_BITS = `PERF_CTR_BITS;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        snap_valid = 1'b0;
  logic        clear_valid = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_idx = 4'd0;
  logic        req_hi = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;

  perf_cache_csr_reader_if #(.CTR_BITS(CTR_BITS)) pc ();

  perf_cache_csr_reader #(.CTR_BITS(CTR_BITS)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .perf_cache_if_i (pc),
    .snap_valid_i    (snap_valid),
`ifdef PERF_CACHE_DELTA_EN
    .clear_valid_i   (clear_valid),
`endif
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_idx_i       (req_idx),
    .req_hi_i        (req_hi),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_data_o      (rsp_data),
    .rsp_err_o       (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one request, check the response the cycle after acceptance, then complete it.
  task automatic read_check(input string tag, input logic [3:0] idx, input logic hi,
                            input logic [31:0] exp_data, input logic exp_err);
    req_idx = idx; req_hi = hi; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_data"}, rsp_data, exp_data);
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_done"}, {30'd0, rsp_valid, req_ready}, 32'd1);
    $display("read %s idx=%0d hi=%0d data=%h err=%0d", tag, idx, hi, exp_data, exp_err);
  endtask

  initial begin
    pc.reads = '0; pc.writes = '0; pc.read_misses = '0; pc.write_misses = '0;
    pc.bank_stalls = '0; pc.mshr_stalls = '0; pc.pipe_stalls = '0; pc.crsp_stalls = '0;
    pc.prefetch_requests = '0; pc.prefetched_blocks = '0; pc.unused_prefetched_blocks = '0;

    tick(); tick();
    reset = 1'b1;
    tick();
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    $display("reset idle check done");

    pc.reads = CTR_BITS'(64'h0AB_CDEF0123);
    snap_valid = 1'b1;
    tick();
    snap_valid = 1'b0;
    read_check("reads_lo", 4'd0, 1'b0, 32'hCDEF0123, 1'b0);
    read_check("reads_hi", 4'd0, 1'b1, 32'h000000AB, 1'b0);

    // Snapshot while a response is held must not disturb the held word.
    req_idx = 4'd0; req_hi = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    pc.reads = CTR_BITS'(64'h111_22223333);
    snap_valid = 1'b1;
    tick();
    snap_valid = 1'b0;
    chk("rsp_snap_hold_data", rsp_data, 32'hCDEF0123);
    chk("rsp_snap_hold_valid", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    $display("snap during RSP: held data checked");
    read_check("reads_new_lo", 4'd0, 1'b0, 32'h22223333, 1'b0);
    read_check("reads_new_hi", 4'd0, 1'b1, 32'h00000111, 1'b0);

    pc.crsp_stalls = CTR_BITS'(5);
    snap_valid = 1'b1;
    tick();
    snap_valid = 1'b0;
    pc.crsp_stalls = CTR_BITS'(9);
    read_check("crsp_old", 4'd7, 1'b0, 32'd5, 1'b0);

    // Snapshot coincident with acceptance: response still shows the pre-snapshot value.
    req_idx = 4'd7; req_hi = 1'b0; req_valid = 1'b1; snap_valid = 1'b1;
    tick();
    req_valid = 1'b0; snap_valid = 1'b0;
    chk("crsp_coinc_data", rsp_data, 32'd5);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    $display("coincident snap+req idx=7 data=5");
    read_check("crsp_new", 4'd7, 1'b0, 32'd9, 1'b0);

    req_idx = 4'd12; req_hi = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("oor_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("oor_hold_data", rsp_data, 32'd0);
      chk("oor_hold_err", {31'd0, rsp_err}, 32'd1);
      chk("oor_hold_ready", {31'd0, req_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("oor_done", {30'd0, rsp_valid, req_ready}, 32'd1);
    $display("out-of-range idx=12 held 4 cycles");
    read_check("oor_idx15", 4'd15, 1'b1, 32'd0, 1'b1);
    read_check("last_idx10", 4'd10, 1'b0, 32'd0, 1'b0);

    // Reset while a response is pending.
    req_idx = 4'd7; req_hi = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_data", rsp_data, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    tick();
    chk("post_rst_no_replay", {31'd0, rsp_valid}, 32'd0);
    $display("reset during RSP aborted response");
    read_check("post_rst_idx0", 4'd0, 1'b0, 32'd0, 1'b0);
    read_check("post_rst_idx7", 4'd7, 1'b0, 32'd0, 1'b0);

`ifdef PERF_CACHE_DELTA_EN
    pc.writes = {CTR_BITS{1'b1}} - CTR_BITS'(2);
    clear_valid = 1'b1;
    tick();
    clear_valid = 1'b0;
    pc.writes = CTR_BITS'(4);
    snap_valid = 1'b1;
    tick();
    snap_valid = 1'b0;
    read_check("delta_wrap_lo", 4'd1, 1'b0, 32'd7, 1'b0);
    read_check("delta_wrap_hi", 4'd1, 1'b1, 32'd0, 1'b0);
    // Clear and snap together: snapshot uses old baseline (writes=2^C-3).
    pc.writes = CTR_BITS'(10);
    clear_valid = 1'b1; snap_valid = 1'b1;
    tick();
    clear_valid = 1'b0; snap_valid = 1'b0;
    read_check("delta_coinc", 4'd1, 1'b0, 32'd13, 1'b0);
    pc.writes = CTR_BITS'(25);
    snap_valid = 1'b1;
    tick();
    snap_valid = 1'b0;
    read_check("delta_new_base", 4'd1, 1'b0, 32'd15, 1'b0);
`else
    pc.writes = CTR_BITS'(64'h3_00000007);
    snap_valid = 1'b1;
    tick();
    snap_valid = 1'b0;
    read_check("direct_lo", 4'd1, 1'b0, 32'd7, 1'b0);
    read_check("direct_hi", 4'd1, 1'b1, 32'd3, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/perf_cache_csr_reader.md
Name: perf_cache_csr_reader

Overview:
Consumer (slave) end of the cache performance-counter interface.
- Captures all 11 cache counters into a coherent shadow bank when a snapshot is requested.
- Serves 32-bit word reads of that bank over a valid/ready request/response channel, for the CSR/DCR read path.
- Sits between a cache's perf counter outputs and the core CSR unit, one instance per cache.

Parameters:
CTR_BITS, `PERF_CTR_BITS, width of each incoming counter; legal range 33..64.
DATA_WIDTH, 32, response word width; fixed at 32.
NUM_CTRS, 11, number of counters (localparam, not overridable).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (reset==0 resets)
perf_cache_if  in  slave modport  live counters, indexed 0..10: reads, writes, read_misses, write_misses, bank_stalls, mshr_stalls, pipe_stalls, crsp_stalls, prefetch_requests, prefetched_blocks, unused_prefetched_blocks
snap_valid  in  1  one-cycle pulse: capture all live counters into the shadow bank
req_valid  in  1  read request valid
req_ready  out  1  read request ready
req_idx  in  4  counter index
req_hi  in  1  0 = bits [31:0]; 1 = bits [CTR_BITS-1:32], zero-extended
rsp_valid  out  1  response valid
rsp_ready  in  1  response ready
rsp_data  out  32  response word
rsp_err  out  1  index out of range (req_idx >= 11)

Behaviour:
- Reset values: shadow bank 0, rsp_valid 0, rsp_data 0, rsp_err 0, FSM in IDLE.
- Reset asserted mid-transaction aborts any pending response; nothing is replayed after reset.

FSM, two states:
- IDLE: req_ready=1, rsp_valid=0. A handshake (req_valid && req_ready) registers rsp_data and rsp_err from the shadow bank, then moves to RSP.
- RSP: req_ready=0, rsp_valid=1. rsp_data and rsp_err are held stable until rsp_ready is sampled high, then return to IDLE.

Timing and throughput:
- Latency: response valid in the cycle after request acceptance.
- Throughput: one request per 2 cycles, since there is no request/response overlap.

Snapshot:
- On snap_valid, all 11 shadow registers load the live counters in the same cycle, so lo/hi word pairs read after one snapshot are coherent.
- snap_valid in the same cycle as request acceptance: the response uses pre-snapshot shadow values; the new values become visible from the next cycle.
- snap_valid while in RSP: shadow updates, but the held rsp_data does not change.

Out-of-range index:
- req_idx 11..15 gives rsp_data=0 and rsp_err=1, still completing the normal handshake.

Width rules:
- The hi word is shadow[CTR_BITS-1:32], zero-extended to 32 bits.
- Counters are treated as unsigned; no saturation is applied.

Optional Feature:
PERF_CACHE_DELTA_EN
- With the macro: adds input port clear_valid (1 bit) and 11 baseline registers (reset 0).
  - clear_valid pulse loads each baseline with its live counter.
  - A snapshot stores live - baseline, modulo 2^CTR_BITS, so counter wrap-around gives the correct delta.
  - clear_valid and snap_valid in the same cycle: the snapshot uses the old baseline; the new baseline applies from the next cycle.
- Without the macro: no clear_valid port, no baseline registers; the snapshot stores the live value directly.

Test Plan:
- Reset, then one idle cycle -> rsp_valid=0, rsp_data=0, rsp_err=0, req_ready=1.
- reads=0x0AB_CDEF0123, snap_valid, then request idx0 hi=0 -> rsp_data=0xCDEF0123 one cycle later; request idx0 hi=1 -> rsp_data=0x00000AB.
- Snapshot with crsp_stalls=5; live changes to 9 with no new snapshot; request idx7 -> rsp_data=5. snap_valid coincident with that request still returns 5; the next request returns 9.
- Request idx12 -> rsp_err=1, rsp_data=0. Hold rsp_ready=0 for 4 cycles -> rsp_valid and rsp_data stable, req_ready=0 throughout.
- Reset driven low while in RSP -> next cycle rsp_valid=0 and shadow cleared; a following idx0 read returns 0.
- DELTA_EN: live writes=2^CTR_BITS-3, clear_valid; live wraps to 4; snap_valid; read idx1 lo -> rsp_data=7.
